mem_bus_responder: RTL and testbench
====================================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- WORD_SIZE, 19, data word width.
- ADDR_SIZE, 19, request address width.
- DEPTH, 256, storage words.
- WAIT_CYCLES, 2, wait states per access (0..15).
REQ-002 Ports SHALL be, one per line:
- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous reset, active low.
- req  in  1  requester access request.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_SIZE  word address.
- wdata  in  WORD_SIZE  write data.
- ack  out  1  one-cycle completion pulse.
- rdata  out  WORD_SIZE  read data, valid with ack.
- busy  out  1  access in progress.
- err  out  1  out-of-range flag, valid with ack (MEM_RESP_ERR_EN only).

Function
REQ-003 FSM SHALL have states IDLE, WAIT, RESP.
REQ-004 In IDLE with req=1, SHALL latch addr, we and wdata at that edge (accept cycle T).
REQ-005 After accept, SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-006 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1, decrement once per cycle, and go to RESP on the cycle after it reads 0.
REQ-007 ack SHALL be 1 for exactly one cycle, in RESP, at cycle T+1+WAIT_CYCLES.
REQ-008 RESP SHALL return to IDLE on the next edge.
REQ-009 A write SHALL update storage at the RESP edge; a read SHALL drive rdata from storage in RESP.
REQ-010 rdata SHALL hold its last value outside RESP; after a write ack it SHALL be unchanged.
REQ-011 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-012 req, addr, we and wdata SHALL be ignored outside IDLE; changing them mid-access SHALL not affect the access.
REQ-013 req held high through ack SHALL start a new access at the IDLE cycle after RESP; back-to-back accesses are spaced by WAIT_CYCLES+2 cycles.
REQ-014 Storage index SHALL be addr modulo DEPTH when MEM_RESP_ERR_EN is undefined.
REQ-015 Storage contents SHALL be undefined until written.

Reset
REQ-016 RESET_N=0 SHALL immediately force IDLE, ack=0, busy=0, rdata=0, err=0 and counter=0, independent of CLK.
REQ-017 Reset during WAIT or RESP SHALL abort the access with no ack and no storage write.
REQ-018 Storage SHALL not be cleared by reset.

Configuration
REQ-019 Macro MEM_RESP_ERR_EN SHALL control range checking.
- Defined: an access with addr>=DEPTH completes with normal latency, err=1 with ack, storage is not written, and rdata=0.
- Undefined: err port SHALL be tied 0 and REQ-014 applies.

Structure
REQ-020 The shared constants package SHALL hold WORD_SIZE and ADDR_SIZE defaults; a shared package SHALL hold the state enum resp_state_t {IDLE, WAIT, RESP}.
REQ-021 Storage SHALL be one sub-module, resp_storage_ram, with a synchronous write port and a combinational read port.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- WAIT_CYCLES=2; write addr 5, data 19'h1ABCD accepted at T -> ack at T+3 and busy=1 for T+1..T+3; read addr 5 -> ack with rdata=19'h1ABCD.
- WAIT_CYCLES=0; read accepted at T -> ack at T+1; req held high -> next accept at T+2.
- WAIT_CYCLES=3; after accept, addr and wdata changed during WAIT -> the original address is written.
- RESET_N low during WAIT of a write to addr 7 (old value 19'h00011) -> no ack, busy=0 immediately; read addr 7 -> 19'h00011.
- MEM_RESP_ERR_EN defined, DEPTH=256; write addr 300 -> err=1 with ack; read addr 44 (alias of 300) -> unchanged value.
- MEM_RESP_ERR_EN undefined; write addr 300 -> read addr 44 returns the written data and err=0.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// mem_bus_responder_pkg: shared width defaults and the responder state type
package mem_bus_responder_pkg;
  localparam int WORD_SIZE_DEF = 19;
  localparam int ADDR_SIZE_DEF = 19;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
endpackage

// File: rtl/mem_bus_responder_if.sv
// mem_bus_responder_if: requester-side memory bus bundle with master/slave views
interface mem_bus_responder_if
  import mem_bus_responder_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
);
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 ack;
  logic [WORD_SIZE-1:0] rdata;
  logic                 busy;
  logic                 err;
  modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
  modport slave (input req, we, addr, wdata, output ack, rdata, busy, err);
endinterface

// File: rtl/mem_bus_responder_storage.sv
// resp_storage_ram: word array with synchronous write and combinational read, never reset
module resp_storage_ram #(
  parameter int WORD_SIZE = 19,
  parameter int DEPTH     = 256,
  parameter int IW        = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IW-1:0]        addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);
  logic [WORD_SIZE-1:0] mem [DEPTH];
  // write port: commits on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: wait-state memory responder; define MEM_RESP_ERR_EN for out-of-range error reporting
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic CLK,
  input logic RESET_N,
  mem_bus_responder_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  resp_state_t          state;
  logic [3:0]           cnt;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] ram_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic [WORD_SIZE-1:0] rd_now;
  logic                 oor;
  logic                 upd;
  logic                 ack;
  logic                 busy;
  logic [IW-1:0]        idx;
  assign idx = IW'(addr_q % ADDR_SIZE'(DEPTH));
`ifdef MEM_RESP_ERR_EN
  assign oor = addr_q >= ADDR_SIZE'(DEPTH);
`else
  assign oor = 1'b0;
`endif
  resp_storage_ram #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH), .IW(IW)) u_ram (
    .clk   (CLK),
    .we    (state == RESP && we_q && !oor),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (ram_q)
  );
  // rdata shows the fresh read (or zero for an out-of-range access) during RESP and the held value otherwise
  assign rd_now    = oor ? '0 : ram_q;
  assign upd       = state == RESP && (!we_q || oor);
  assign bus.rdata = upd ? rd_now : rdata_q;
  assign bus.err   = state == RESP && oor;
  assign bus.ack   = ack;
  assign bus.busy  = busy;
  // access sequencer: accept in IDLE, count wait states, pulse ack for one RESP cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          we_q    <= bus.we;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
          busy    <= 1'b1;
          cnt     <= WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
          state   <= WAIT_CYCLES > 0 ? WAIT : RESP;
          ack     <= WAIT_CYCLES == 0;
        end
        WAIT: if (cnt == 4'd0) begin
          state <= RESP;
          ack   <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
          if (upd) rdata_q <= rd_now;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: three responders (2/0/3 wait states) checked against an array reference model
module tb_mem_bus_responder;
  localparam int W = 19;
  localparam int A = 19;
  localparam int D = 256;
  localparam int WC [3] = '{2, 0, 3};
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   req = '0;
  logic [2:0]   we = '0;
  logic [A-1:0] addr [3];
  logic [W-1:0] wdata [3];
  logic [2:0]   ack, busy, err;
  logic [W-1:0] rdata [3];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] mdl [3][D];
  logic [W-1:0] last_rd [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    mem_bus_responder_if #(.WORD_SIZE(W), .ADDR_SIZE(A)) bus ();
    mem_bus_responder #(.WORD_SIZE(W), .ADDR_SIZE(A), .DEPTH(D), .WAIT_CYCLES(WC[g])) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus.slave)
    );
    assign bus.req   = req[g];
    assign bus.we    = we[g];
    assign bus.addr  = addr[g];
    assign bus.wdata = wdata[g];
    assign ack[g]    = bus.ack;
    assign busy[g]   = bus.busy;
    assign err[g]    = bus.err;
    assign rdata[g]  = bus.rdata;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input int g, input bit w, input logic [A-1:0] a, input logic [W-1:0] d);
    int lat;
    bit bz;
    bit oor;
    int ix;
    logic [W-1:0] exp_rd;
    req[g] = 1'b1; we[g] = w; addr[g] = a; wdata[g] = d;
    cyc();
    req[g] = 1'b0; we[g] = ~w; addr[g] = a ^ A'(1); wdata[g] = ~d;
    lat = 1;
    bz = 1'b1;
    while (!ack[g] && lat < 40) begin
      bz &= busy[g];
      cyc();
      lat++;
    end
    bz &= busy[g];
    ix = int'(a) % D;
    oor = ERR_EN && int'(a) >= D;
    exp_rd = oor ? '0 : (w ? last_rd[g] : mdl[g][ix]);
    chk($sformatf("latency[%0d]", g), lat, WC[g] + 1);
    chk($sformatf("busy_during[%0d]", g), {31'd0, bz}, 1);
    chk($sformatf("rdata[%0d] a=%0d w=%0d", g, a, w), {13'd0, rdata[g]}, {13'd0, exp_rd});
    chk($sformatf("err[%0d]", g), {31'd0, err[g]}, {31'd0, oor});
    if (w && !oor) mdl[g][ix] = d;
    last_rd[g] = exp_rd;
    cyc();
    chk($sformatf("ack_one_cycle[%0d]", g), {31'd0, ack[g]}, 0);
    chk($sformatf("busy_idle[%0d]", g), {31'd0, busy[g]}, 0);
  endtask
  initial begin
    for (int g = 0; g < 3; g++) begin
      addr[g] = '0; wdata[g] = '0; last_rd[g] = '0;
    end
    #12;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_ack[%0d]", g), {31'd0, ack[g]}, 0);
      chk($sformatf("reset_busy[%0d]", g), {31'd0, busy[g]}, 0);
      chk($sformatf("reset_err[%0d]", g), {31'd0, err[g]}, 0);
      chk($sformatf("reset_rdata[%0d]", g), {13'd0, rdata[g]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 16; i++) access(g, 1'b1, A'(i), W'($urandom));
    access(0, 1'b1, A'(5), W'('h1ABCD));
    access(0, 1'b0, A'(5), '0);
    chk("read_back_5", {13'd0, rdata[0]}, 32'h1ABCD);
    access(1, 1'b1, A'(9), W'('h0F0F0));
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = A'(9);
    cyc();
    chk("b2b_first_ack", {31'd0, ack[1]}, 1);
    chk("b2b_first_rdata", {13'd0, rdata[1]}, 32'h0F0F0);
    cyc();
    chk("b2b_gap_ack", {31'd0, ack[1]}, 0);
    chk("b2b_gap_busy", {31'd0, busy[1]}, 0);
    cyc();
    chk("b2b_second_ack", {31'd0, ack[1]}, 1);
    req[1] = 1'b0;
    cyc();
    chk("b2b_done_ack", {31'd0, ack[1]}, 0);
    last_rd[1] = W'('h0F0F0);
    access(2, 1'b1, A'(31), W'('h00031));
    access(2, 1'b1, A'(30), W'('h07777));
    access(2, 1'b0, A'(30), '0);
    chk("midchange_orig", {13'd0, rdata[2]}, 32'h07777);
    access(2, 1'b0, A'(31), '0);
    chk("midchange_other", {13'd0, rdata[2]}, 32'h00031);
    access(0, 1'b1, A'(7), W'('h00011));
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = A'(7); wdata[0] = W'('h2222);
    cyc();
    req[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort_ack", {31'd0, ack[0]}, 0);
    chk("rst_abort_busy", {31'd0, busy[0]}, 0);
    chk("rst_abort_rdata", {13'd0, rdata[0]}, 0);
    cyc();
    chk("rst_hold_ack", {31'd0, ack[0]}, 0);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) last_rd[g] = '0;
    cyc();
    chk("rst_idle_after", {31'd0, busy[0]}, 0);
    access(0, 1'b0, A'(7), '0);
    chk("rst_storage_kept", {13'd0, rdata[0]}, 32'h00011);
    access(0, 1'b1, A'(44), W'('h04444));
    access(0, 1'b1, A'(300), W'('h13579));
    access(0, 1'b0, A'(44), '0);
    chk("alias_44", {13'd0, rdata[0]}, ERR_EN ? 32'h04444 : 32'h13579);
    for (int n = 0; n < 40; n++) begin
      int g;
      g = int'($urandom_range(0, 2));
      access(g, 1'($urandom), A'($urandom_range(0, 15) + ($urandom_range(0, 4) == 0 ? 256 : 0)), W'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
